sobel_stream: RTL and testbench
===============================

Name: sobel_stream

Overview:
Streaming, fully parametrised Sobel edge filter. Accepts one raster-order frame, pixel by pixel, over a valid/ready handshake. Buffers two image lines internally, so each input pixel is fetched once and there is no random-access image memory. Emits one gradient result per interior pixel, with row/col tags, in either magnitude or binary-threshold mode.

Parameters:
IMG_WIDTH, 8, pixels per line (>=3)
IMG_HEIGHT, 8, lines per frame (>=3)
DATA_WIDTH, 8, bits per input pixel
CW, $clog2(IMG_WIDTH>IMG_HEIGHT?IMG_WIDTH:IMG_HEIGHT), row/col tag width (derived; do not override)

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse; arms a frame when in IDLE
mode  in  1  0 = magnitude output, 1 = binary threshold output
threshold  in  DATA_WIDTH+3  compare level for mode 1; sampled at start
in_valid  in  1  input pixel valid
in_ready  out  1  block can accept a pixel this cycle
in_data  in  DATA_WIDTH  pixel, unsigned, raster order
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_data  out  DATA_WIDTH+3  gradient or threshold result
out_row  out  CW  centre row of result (1..IMG_HEIGHT-2)
out_col  out  CW  centre col of result (1..IMG_WIDTH-2)
out_last  out  1  high with the final result of the frame
done  out  1  one-cycle pulse after the last result is accepted

Behaviour:
- Reset (rst_n low, async): state IDLE. in_ready, out_valid, out_last, done = 0. out_data, out_row, out_col = 0. Input row/col counters = 0. Line buffers are not cleared.
- FSM: IDLE -> RUN on start, which latches mode and threshold and clears the counters. RUN -> FLUSH when the last pixel (IMG_HEIGHT-1, IMG_WIDTH-1) is accepted. FLUSH -> IDLE when the final result is accepted (out_valid & out_ready); done pulses on that transition cycle+1. start outside IDLE is ignored.
- Input transfer: a pixel is accepted when in_valid & in_ready. in_ready = (state==RUN) & (~out_valid | out_ready). in_data is ignored when the transfer does not occur.
- Storage: two line buffers of IMG_WIDTH x DATA_WIDTH hold rows r-1 and r-2, plus a 3x3 window shift register that shifts one column per accepted pixel. Column counter wraps at IMG_WIDTH-1 and increments the row counter.
- Result generation: accepting pixel (r,c) with r>=2 and c>=2 produces the result for centre (r-1,c-1). out_valid is set on the next rising edge, so latency is 1 cycle from the accepting edge. Border pixels produce no output. There are exactly (IMG_WIDTH-2)*(IMG_HEIGHT-2) results, in raster order of centre.
- Arithmetic (window pRC, R = row offset 0..2, C = col offset 0..2, unsigned inputs):
  - Gx = (p02+2p12+p22) - (p00+2p10+p20)
  - Gy = (p20+2p21+p22) - (p00+2p01+p02)
  - Intermediates are signed, DATA_WIDTH+4 bits.
  - mag = |Gx| + |Gy|, max 8*(2^DATA_WIDTH-1), fits DATA_WIDTH+3 bits, no saturation.
  - mode 0: out_data = mag. mode 1: out_data = all-ones if mag >= threshold, else 0.
- Output hold: while out_valid & ~out_ready, out_data, out_row, out_col and out_last stay stable, and in_ready = 0. A result accepted in the same cycle a new one is produced is replaced with no bubble.
- out_last is high only alongside centre (IMG_HEIGHT-2, IMG_WIDTH-2).
- Reset mid-frame: immediate return to IDLE. Any pending result is dropped and no done pulse is issued. The next frame requires start.
- in_valid gaps: processing stalls and no state changes.

Test Plan:
1. 8x8 frame, all pixels 50, mode 0 -> 36 results, all out_data=0, out_row/out_col step 1..6 in raster order, out_last on (6,6), done pulses once.
2. Vertical step: cols 0-3 = 0, cols 4-7 = 100, mode 0 -> out_data=400 at cols 3 and 4 of every row, 0 elsewhere.
3. Same image, mode 1, threshold=400 -> 2047 at cols 3,4, else 0. Repeat with threshold=401 -> all 0.
4. Extremes, DATA_WIDTH=8: pixel 255 where row+col>=8, else 0, mode 0 -> values match the reference model bit-exactly; no result exceeds 2040, and no overflow occurs.
5. Backpressure: out_ready low for 5 cycles after the first result -> in_ready=0, out_* held stable. Toggling out_ready 1/0 randomly still yields the identical 36-result sequence. in_valid random gaps give the same results.
6. rst_n low after 20 pixels -> out_valid=0, in_ready=0 asynchronously, no done. New start plus a full frame -> correct 36 results. Also run IMG_WIDTH=10, IMG_HEIGHT=5 -> 24 results, out_last on (3,8).

Source files
------------

// File: rtl/sobel_stream.sv
// sobel_stream
// Streaming 3x3 Sobel edge filter over one raster-order frame.
// Pixels arrive over a valid/ready handshake and are each fetched exactly once.
// Two line buffers hold the previous two image rows. A two-column window holds
// the last two columns, so together with the incoming pixel a full 3x3
// neighbourhood is available. One result is produced per interior pixel.
//
// Ports:
//   clk, rst_n             clock (rising edge), asynchronous active-low reset
//   start                  one-cycle pulse, arms a frame while idle
//   mode, threshold        0 = |Gx|+|Gy|, 1 = all-ones/zero against threshold
//   in_valid/in_ready      input pixel handshake, in_data unsigned pixel
//   out_valid/out_ready    result handshake
//   out_data               gradient magnitude or threshold flag
//   out_row, out_col       centre coordinates of the result
//   out_last               marks the final result of the frame
//   done                   pulse the cycle after the final result is taken
module sobel_stream #(
    parameter int IMG_WIDTH  = 8,
    parameter int IMG_HEIGHT = 8,
    parameter int DATA_WIDTH = 8,
    parameter int CW = $clog2(IMG_WIDTH > IMG_HEIGHT ? IMG_WIDTH : IMG_HEIGHT)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  mode,
    input  logic [DATA_WIDTH+2:0] threshold,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH+2:0] out_data,
    output logic [CW-1:0]         out_row,
    output logic [CW-1:0]         out_col,
    output logic                  out_last,
    output logic                  done
);

    localparam int OW = DATA_WIDTH + 3;
    localparam int SW = DATA_WIDTH + 4;
    localparam logic [CW-1:0] LAST_COL = CW'(IMG_WIDTH - 1);
    localparam logic [CW-1:0] LAST_ROW = CW'(IMG_HEIGHT - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH
    } state_t;

    state_t                  state;
    logic                    mode_q;
    logic [OW-1:0]           thr_q;
    logic [CW-1:0]           row_cnt;
    logic [CW-1:0]           col_cnt;

    // line_r1 holds row r-1, line_r2 holds row r-2 (indexed by column)
    logic [DATA_WIDTH-1:0]   line_r1 [IMG_WIDTH];
    logic [DATA_WIDTH-1:0]   line_r2 [IMG_WIDTH];
    // win_a = column c-2, win_b = column c-1; index 0 is the top row
    logic [DATA_WIDTH-1:0]   win_a [3];
    logic [DATA_WIDTH-1:0]   win_b [3];

    logic [DATA_WIDTH-1:0]   col_top;
    logic [DATA_WIDTH-1:0]   col_mid;
    logic                    accept;
    logic                    last_pix;
    logic                    produce;
    logic signed [SW-1:0]    gx;
    logic signed [SW-1:0]    gy;
    logic [SW-1:0]           abs_x;
    logic [SW-1:0]           abs_y;
    logic [SW-1:0]           mag;
    logic [OW-1:0]           result;

    function automatic logic signed [SW-1:0] ext(input logic [DATA_WIDTH-1:0] p);
        return $signed({4'b0000, p});
    endfunction

    assign in_ready = (state == RUN) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign last_pix = (row_cnt == LAST_ROW) && (col_cnt == LAST_COL);
    assign produce  = accept && (row_cnt >= CW'(2)) && (col_cnt >= CW'(2));
    assign col_top  = line_r2[col_cnt];
    assign col_mid  = line_r1[col_cnt];

    // The incoming column (col_top, col_mid, in_data) is the right-hand
    // column of the window, so the result is computed before the shift.
    always_comb begin
        gx = (ext(col_top) + ext(col_mid) + ext(col_mid) + ext(in_data))
           - (ext(win_a[0]) + ext(win_a[1]) + ext(win_a[1]) + ext(win_a[2]));
        gy = (ext(win_a[2]) + ext(win_b[2]) + ext(win_b[2]) + ext(in_data))
           - (ext(win_a[0]) + ext(win_b[0]) + ext(win_b[0]) + ext(col_top));
        abs_x = gx[SW-1] ? SW'(-gx) : SW'(gx);
        abs_y = gy[SW-1] ? SW'(-gy) : SW'(gy);
        mag   = abs_x + abs_y;
        if (mode_q) begin
            result = (mag >= {1'b0, thr_q}) ? {OW{1'b1}} : {OW{1'b0}};
        end else begin
            result = mag[OW-1:0];
        end
    end

    // Pixel storage is not reset; border rows/cols never produce results,
    // so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (accept) begin
            line_r2[col_cnt] <= col_mid;
            line_r1[col_cnt] <= in_data;
            win_a[0] <= win_b[0];
            win_a[1] <= win_b[1];
            win_a[2] <= win_b[2];
            win_b[0] <= col_top;
            win_b[1] <= col_mid;
            win_b[2] <= in_data;
        end
    end

    // Frame control, position counters and the registered result stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mode_q    <= 1'b0;
            thr_q     <= '0;
            row_cnt   <= '0;
            col_cnt   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_row   <= '0;
            out_col   <= '0;
            out_last  <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= RUN;
                        mode_q  <= mode;
                        thr_q   <= threshold;
                        row_cnt <= '0;
                        col_cnt <= '0;
                    end
                end
                RUN: begin
                    if (accept) begin
                        if (last_pix) begin
                            state   <= FLUSH;
                            row_cnt <= '0;
                            col_cnt <= '0;
                        end else if (col_cnt == LAST_COL) begin
                            col_cnt <= '0;
                            row_cnt <= row_cnt + CW'(1);
                        end else begin
                            col_cnt <= col_cnt + CW'(1);
                        end
                    end
                end
                FLUSH: begin
                    if (out_valid && out_ready) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            // produce implies the previous result is gone or leaving now,
            // so a new result may overwrite the register without a bubble.
            if (produce) begin
                out_valid <= 1'b1;
                out_data  <= result;
                out_row   <= row_cnt - CW'(1);
                out_col   <= col_cnt - CW'(1);
                out_last  <= last_pix;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sobel_stream.sv
module tb_sobel_stream;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_a;
    logic        start_b;
    logic        mode;
    logic [10:0] threshold;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        out_ready;

    logic        in_ready_a, out_valid_a, out_last_a, done_a;
    logic [10:0] out_data_a;
    logic [2:0]  out_row_a, out_col_a;
    logic        in_ready_b, out_valid_b, out_last_b, done_b;
    logic [10:0] out_data_b;
    logic [3:0]  out_row_b, out_col_b;

    int checks = 0;
    int errors = 0;

    int img [10][10];
    int res_data [$];
    int res_row [$];
    int res_col [$];
    int res_last [$];
    int done_cnt;
    bit timed_out;

    sobel_stream #(.IMG_WIDTH(8), .IMG_HEIGHT(8), .DATA_WIDTH(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .mode(mode),
        .threshold(threshold), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_data(in_data), .out_valid(out_valid_a), .out_ready(out_ready),
        .out_data(out_data_a), .out_row(out_row_a), .out_col(out_col_a),
        .out_last(out_last_a), .done(done_a)
    );

    sobel_stream #(.IMG_WIDTH(10), .IMG_HEIGHT(5), .DATA_WIDTH(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .mode(mode),
        .threshold(threshold), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_data(in_data), .out_valid(out_valid_b), .out_ready(out_ready),
        .out_data(out_data_b), .out_row(out_row_b), .out_col(out_col_b),
        .out_last(out_last_b), .done(done_b)
    );

    always #5 clk = ~clk;

    // Independent reference: direct 3x3 neighbourhood over the stored image
    function automatic int ref_mag(input int r, input int c);
        int gx, gy;
        gx = (img[r-1][c+1] + 2*img[r][c+1] + img[r+1][c+1])
           - (img[r-1][c-1] + 2*img[r][c-1] + img[r+1][c-1]);
        gy = (img[r+1][c-1] + 2*img[r+1][c] + img[r+1][c+1])
           - (img[r-1][c-1] + 2*img[r-1][c] + img[r-1][c+1]);
        if (gx < 0) gx = -gx;
        if (gy < 0) gy = -gy;
        return gx + gy;
    endfunction

    // Runs one full frame on the selected instance and records all results
    task automatic run_frame(input bit sel, input bit bp, input bit gaps);
        int w, h, n, pi, cyc, extra;
        bit ov, ir, dn;
        w = sel ? 10 : 8;
        h = sel ? 5 : 8;
        n = (w - 2) * (h - 2);
        res_data.delete(); res_row.delete(); res_col.delete(); res_last.delete();
        done_cnt = 0;
        timed_out = 0;
        @(negedge clk);
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        pi = 0; cyc = 0; extra = 0;
        while (!(res_data.size() >= n && extra >= 3) && cyc < 3000) begin
            out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            in_valid  = (pi < w*h) && (gaps ? ($urandom_range(0, 3) != 0) : 1'b1);
            in_data   = (pi < w*h) ? 8'(img[pi/w][pi%w]) : 8'd0;
            #1;
            ov = sel ? out_valid_b : out_valid_a;
            ir = sel ? in_ready_b : in_ready_a;
            dn = sel ? done_b : done_a;
            if (ov && out_ready) begin
                res_data.push_back(sel ? int'(out_data_b) : int'(out_data_a));
                res_row.push_back(sel ? int'(out_row_b) : int'(out_row_a));
                res_col.push_back(sel ? int'(out_col_b) : int'(out_col_a));
                res_last.push_back(sel ? int'(out_last_b) : int'(out_last_a));
            end
            if (in_valid && ir) pi++;
            if (dn) done_cnt++;
            if (res_data.size() >= n) extra++;
            cyc++;
            @(negedge clk);
        end
        if (cyc >= 3000) timed_out = 1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; start_a = 0; start_b = 0; mode = 0; threshold = '0;
        in_valid = 0; in_data = '0; out_ready = 1'b1;
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready_a, out_valid_a, out_last_a, done_a} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_flags: got %b expected 0000",
                     {in_ready_a, out_valid_a, out_last_a, done_a});
        end
        checks++;
        if (out_data_a !== 11'd0 || out_row_a !== 3'd0 || out_col_a !== 3'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got data %0d row %0d col %0d expected 0 0 0",
                     out_data_a, out_row_a, out_col_a);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (in_ready_a !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_in_ready: got %b expected 0", in_ready_a);
        end
    endtask

    task automatic test_flat();
        for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) img[r][c] = 50;
        mode = 0;
        run_frame(0, 0, 0);
        checks++;
        if (timed_out || res_data.size() != 36) begin
            errors++;
            $display("[TB] FAIL flat_count: got %0d results (timeout %0d) expected 36",
                     res_data.size(), timed_out);
        end
        for (int i = 0; i < res_data.size(); i++) begin
            checks++;
            if (res_data[i] != 0 || res_row[i] != 1 + i/6 || res_col[i] != 1 + i%6
                || res_last[i] != ((i == 35) ? 1 : 0)) begin
                errors++;
                $display("[TB] FAIL flat_result %0d: got data %0d row %0d col %0d last %0d expected 0 %0d %0d %0d",
                         i, res_data[i], res_row[i], res_col[i], res_last[i], 1 + i/6, 1 + i%6, (i == 35));
            end
        end
        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("[TB] FAIL flat_done: got %0d pulses expected 1", done_cnt);
        end
    endtask

    task automatic test_step(input bit m, input int thr, input int hit_val, input bit bp);
        int exp_v;
        for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) img[r][c] = (c >= 4) ? 100 : 0;
        mode = m;
        threshold = 11'(thr);
        run_frame(0, bp, bp);
        threshold = '0;
        checks++;
        if (timed_out || res_data.size() != 36) begin
            errors++;
            $display("[TB] FAIL step_count m%0d t%0d: got %0d results expected 36",
                     m, thr, res_data.size());
        end
        for (int i = 0; i < res_data.size(); i++) begin
            exp_v = (1 + i%6 == 3 || 1 + i%6 == 4) ? hit_val : 0;
            checks++;
            if (res_data[i] != exp_v || res_row[i] != 1 + i/6 || res_col[i] != 1 + i%6) begin
                errors++;
                $display("[TB] FAIL step_result m%0d t%0d idx %0d: got %0d at (%0d,%0d) expected %0d at (%0d,%0d)",
                         m, thr, i, res_data[i], res_row[i], res_col[i], exp_v, 1 + i/6, 1 + i%6);
            end
        end
        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("[TB] FAIL step_done: got %0d pulses expected 1", done_cnt);
        end
    endtask

    task automatic test_extremes();
        for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) img[r][c] = (r + c >= 8) ? 255 : 0;
        mode = 0;
        run_frame(0, 0, 0);
        checks++;
        if (timed_out || res_data.size() != 36) begin
            errors++;
            $display("[TB] FAIL ext_count: got %0d expected 36", res_data.size());
        end
        for (int i = 0; i < res_data.size(); i++) begin
            checks++;
            if (res_data[i] != ref_mag(1 + i/6, 1 + i%6) || res_data[i] > 2040) begin
                errors++;
                $display("[TB] FAIL ext_result %0d: got %0d expected %0d",
                         i, res_data[i], ref_mag(1 + i/6, 1 + i%6));
            end
        end
        if (res_data.size() == 36) begin
            checks++;
            if (res_data[21] != 1530) begin
                errors++;
                $display("[TB] FAIL ext_centre_4_4: got %0d expected 1530", res_data[21]);
            end
        end
    endtask

    task automatic test_backpressure();
        int pi, cyc;
        for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) img[r][c] = r*10 + c*3;
        mode = 0;
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        out_ready = 1'b0;
        pi = 0; cyc = 0;
        while (cyc < 200) begin
            in_valid = 1'b1;
            in_data  = 8'(img[pi/8][pi%8]);
            #1;
            if (out_valid_a) break;
            if (in_ready_a) pi++;
            cyc++;
            @(negedge clk);
        end
        checks++;
        if (!out_valid_a || pi != 19) begin
            errors++;
            $display("[TB] FAIL bp_first_result: got valid %b after %0d pixels expected 1 after 19",
                     out_valid_a, pi);
        end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (in_ready_a !== 1'b0 || out_valid_a !== 1'b1 || out_data_a !== 11'd104
                || out_row_a !== 3'd1 || out_col_a !== 3'd1 || out_last_a !== 1'b0) begin
                errors++;
                $display("[TB] FAIL bp_hold %0d: got rdy %b vld %b data %0d (%0d,%0d) expected 0 1 104 (1,1)",
                         k, in_ready_a, out_valid_a, out_data_a, out_row_a, out_col_a);
            end
            @(negedge clk);
            #1;
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready_a !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bp_release: got in_ready %b expected 1", in_ready_a);
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        test_step(0, 0, 400, 1);
    endtask

    task automatic test_mid_reset();
        int pi, cyc, dn;
        for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) img[r][c] = (c >= 4) ? 100 : 0;
        mode = 0;
        out_ready = 1'b1;
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        pi = 0; cyc = 0;
        while (pi < 20 && cyc < 200) begin
            in_valid = 1'b1;
            in_data  = 8'(img[pi/8][pi%8]);
            #1;
            if (in_ready_a) pi++;
            cyc++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid_a !== 1'b1 || out_col_a !== 3'd2) begin
            errors++;
            $display("[TB] FAIL mid_pre_reset: got valid %b col %0d expected 1 2", out_valid_a, out_col_a);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid_a !== 1'b0 || in_ready_a !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_async_reset: got valid %b ready %b expected 0 0", out_valid_a, in_ready_a);
        end
        dn = 0;
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            if (done_a) dn++;
            checks++;
            if (in_ready_a !== 1'b0) begin
                errors++;
                $display("[TB] FAIL mid_no_start_ready: got %b expected 0", in_ready_a);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        checks++;
        if (dn != 0) begin
            errors++;
            $display("[TB] FAIL mid_no_done: got %0d pulses expected 0", dn);
        end
        test_step(0, 0, 400, 0);
    endtask

    task automatic test_small_frame();
        for (int r = 0; r < 5; r++) for (int c = 0; c < 10; c++) img[r][c] = r*10 + c*3;
        mode = 0;
        run_frame(1, 1, 1);
        checks++;
        if (timed_out || res_data.size() != 24) begin
            errors++;
            $display("[TB] FAIL small_count: got %0d expected 24", res_data.size());
        end
        for (int i = 0; i < res_data.size(); i++) begin
            checks++;
            if (res_data[i] != 104 || res_row[i] != 1 + i/8 || res_col[i] != 1 + i%8
                || res_last[i] != ((i == 23) ? 1 : 0)) begin
                errors++;
                $display("[TB] FAIL small_result %0d: got %0d (%0d,%0d) last %0d expected 104 (%0d,%0d) %0d",
                         i, res_data[i], res_row[i], res_col[i], res_last[i], 1 + i/8, 1 + i%8, (i == 23));
            end
        end
        if (res_data.size() == 24) begin
            checks++;
            if (res_row[23] != 3 || res_col[23] != 8 || res_last[23] != 1) begin
                errors++;
                $display("[TB] FAIL small_last: got (%0d,%0d) last %0d expected (3,8) 1",
                         res_row[23], res_col[23], res_last[23]);
            end
        end
        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("[TB] FAIL small_done: got %0d expected 1", done_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_flat();
        test_step(0, 0, 400, 0);
        test_step(1, 400, 2047, 0);
        test_step(1, 401, 0, 0);
        test_extremes();
        test_backpressure();
        test_mid_reset();
        test_small_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
